print_spooler: RTL
==================

PRINT_SPOOLER -- requirements
Module: print_spooler

Interface
REQ-001 Parameter DEPTH, default 4: job FIFO entries, power of two, 2..16.
REQ-002 Parameter TIMEOUT, default 15: max cycles in WAIT_START before abandoning a job, 1..255.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 job_valid  input  1  host offers a job this cycle.
REQ-006 job_pages  input  8  page count of offered job.
REQ-007 job_ready  output  1  spooler can accept a job (combinational, = !full).
REQ-008 warm, loadpage, printpage  input  1 each  status fed back from downstream print controller.
REQ-009 push  output  1  registered one-cycle job-start strobe to print controller.
REQ-010 pages  output  8  registered page count, valid while push=1, held otherwise.
REQ-011 job_done  output  1  one-cycle pulse when controller returns idle after a job.
REQ-012 job_reject  output  1  one-cycle pulse, registered, when a zero-page job is offered.
REQ-013 err_timeout  output  1  sticky flag, set on WAIT_START timeout, cleared only by reset.
REQ-014 jobs_pending  output  5  FIFO occupancy, 0..DEPTH.
REQ-015 pages_printed  output  16  count of printpage rising edges, saturating.

Function
REQ-016 Accept = job_valid & job_ready & (job_pages!=0); writes job_pages to FIFO tail at that edge.
REQ-017 job_valid & job_ready & job_pages==0: nothing written; job_reject=1 the following cycle.
REQ-018 Full FIFO: job_ready=0; a same-cycle pop does not enable a same-cycle write.
REQ-019 FSM states IDLE, ISSUE, WAIT_START, BUSY; encoding in shared package.
REQ-020 IDLE -> ISSUE when FIFO non-empty; job accepted at edge k into empty FIFO gives push=1 during cycle k+1..k+2 (one cycle).
REQ-021 ISSUE: push=1, pages=FIFO head; at next edge pop head, clear timeout counter, go WAIT_START.
REQ-022 WAIT_START: warm=1 -> BUSY; else counter increments; counter==TIMEOUT -> set err_timeout, go IDLE without job_done.
REQ-023 BUSY: warm|loadpage|printpage==0 for one cycle -> IDLE, job_done=1 in the first IDLE cycle.
REQ-024 pages_printed increments on printpage 0->1 (registered previous value) in any state; holds at 16'hFFFF.
REQ-025 Simultaneous accept and pop: jobs_pending unchanged, pointers wrap modulo DEPTH.
REQ-026 Only one job outstanding at the controller; push never reasserts before job_done or timeout.

Reset
REQ-027 rst_n low: state IDLE, FIFO empty, push=0, pages=0, job_done=0, job_reject=0, err_timeout=0, pages_printed=0, timeout counter=0, immediately and asynchronously.
REQ-028 Reset mid-job discards all queued and in-flight jobs; no job_done issued.

Structure
REQ-029 Shared package print_pkg holds state typedef, PAGE_W=8, and status-decode constants reused by print controller.
REQ-030 One sub-module: spool_fifo (parameterised DEPTH x 8 synchronous FIFO with count, full, empty).

Verification
REQ-031 Single job: job_pages=3 at edge 0 -> push=1 cycle 1 with pages=3; model controller; job_done after idle; pages_printed=3.
REQ-032 Back-to-back: 5 jobs offered with DEPTH=4 while BUSY -> job_ready=0 after 4th, 5th stalled until pop; jobs issue in order.
REQ-033 Zero-page job_pages=0 -> job_reject pulse, jobs_pending stays 0, no push.
REQ-034 Controller never warms -> err_timeout=1 after TIMEOUT=15 cycles in WAIT_START; next queued job still issues.
REQ-035 rst_n low during BUSY with 2 queued -> all outputs zero at once, jobs_pending=0, no job_done after release.
REQ-036 65540 printpage edges -> pages_printed saturates at 16'hFFFF.

Source files
------------

// File: rtl/print_pkg.sv
// Shared definitions for the print spooler and the downstream print controller.
// Holds the spooler FSM state encoding, the page-count width, and the
// controller status-vector layout. The controller status is {printpage, loadpage, warm}.
package print_pkg;

   localparam int PAGE_W = 8;
   localparam int CNT_W  = 16;
   localparam int STAT_W = 3;

   // Bit masks into the {printpage, loadpage, warm} status vector
   localparam logic [STAT_W-1:0] STAT_WARM  = 3'b001;
   localparam logic [STAT_W-1:0] STAT_LOAD  = 3'b010;
   localparam logic [STAT_W-1:0] STAT_PRINT = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_ISSUE      = 2'd1,
      ST_WAIT_START = 2'd2,
      ST_BUSY       = 2'd3
   } spool_state_t;

   // Controller is considered idle only when no status line is asserted
   function automatic logic ctrl_active(input logic [STAT_W-1:0] status);
      return (status & (STAT_WARM | STAT_LOAD | STAT_PRINT)) != '0;
   endfunction

endpackage

// File: rtl/print_spooler_if.sv
// Handshake bundle between host, spooler and print controller.
//   job_valid/job_pages/job_ready : host job offer (ready = FIFO not full)
//   warm/loadpage/printpage       : status from the print controller
//   push/pages                    : job-start strobe and page count to the controller
// slave  : the spooler side
// master : the host/controller side
interface print_spooler_if;
   import print_pkg::*;

   logic              job_valid;
   logic [PAGE_W-1:0] job_pages;
   logic              job_ready;
   logic              warm;
   logic              loadpage;
   logic              printpage;
   logic              push;
   logic [PAGE_W-1:0] pages;

   modport slave (
      input  job_valid, job_pages, warm, loadpage, printpage,
      output job_ready, push, pages
   );

   modport master (
      output job_valid, job_pages, warm, loadpage, printpage,
      input  job_ready, push, pages
   );

endinterface

// File: rtl/print_spooler_fifo.sv
// spool_fifo: DEPTH x PAGE_W synchronous FIFO holding queued job page counts.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset (pointers/count only)
//   wr_en, wr_data    : write at tail (ignored when full)
//   rd_en             : pop head (ignored when empty)
//   rd_data           : current head entry (combinational)
//   count, full, empty: occupancy status
module spool_fifo
   import print_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [PAGE_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [PAGE_W-1:0] rd_data,
   output logic [4:0]        count,
   output logic              full,
   output logic              empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PAGE_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              wr_ok;
   logic              rd_ok;

   assign full    = (count == 5'(DEPTH));
   assign empty   = (count == 5'd0);
   assign wr_ok   = wr_en & ~full;
   assign rd_ok   = rd_en & ~empty;
   assign rd_data = mem[rd_ptr];

   // Storage is not reset; only pointers and occupancy carry state meaning
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Power-of-two DEPTH lets the pointers wrap by natural overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 5'd1;
            2'b01:   count <= count - 5'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/print_spooler.sv
// print_spooler: queues host print jobs and hands them one at a time to a
// downstream print controller, watching its status lines for start/finish.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   bus (slave)   : job offer handshake, controller status in, push/pages out
//   job_done      : one-cycle pulse when the controller returns idle after a job
//   job_reject    : one-cycle pulse the cycle after a zero-page job is offered
//   err_timeout   : sticky, set when the controller never warms up for a job
//   jobs_pending  : FIFO occupancy
//   pages_printed : saturating count of printpage rising edges
module print_spooler
   import print_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   print_spooler_if.slave    bus,
   output logic              job_done,
   output logic              job_reject,
   output logic              err_timeout,
   output logic [4:0]        jobs_pending,
   output logic [CNT_W-1:0]  pages_printed
);

   localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

   spool_state_t      state;
   logic [7:0]        tmo_cnt;
   logic              push_q;
   logic [PAGE_W-1:0] pages_q;
   logic [PAGE_W-1:0] head;
   logic [4:0]        count;
   logic              full;
   logic              empty;
   logic              offer;
   logic              accept;
   logic              pop;
   logic [STAT_W-1:0] status;
   logic              printpage_p1;
   logic [CNT_W-1:0]  print_cnt;

   assign status        = {bus.printpage, bus.loadpage, bus.warm};
   assign bus.job_ready = ~full;
   assign bus.push      = push_q;
   assign bus.pages     = pages_q;
   assign jobs_pending  = count;
   assign pages_printed = print_cnt;

   // A pop in the same cycle never frees a slot for a same-cycle write
   assign offer  = bus.job_valid & ~full;
   assign accept = offer & (bus.job_pages != '0);
   assign pop    = (state == ST_ISSUE);

   spool_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (accept),
      .wr_data (bus.job_pages),
      .rd_en   (pop),
      .rd_data (head),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

   // Job sequencing; push/pages/job_done/err_timeout are all registered here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         tmo_cnt     <= '0;
         push_q      <= 1'b0;
         pages_q     <= '0;
         job_done    <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         job_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!empty) begin
                  state   <= ST_ISSUE;
                  push_q  <= 1'b1;
                  pages_q <= head;
               end
            end
            ST_ISSUE: begin
               push_q  <= 1'b0;
               tmo_cnt <= '0;
               state   <= ST_WAIT_START;
            end
            ST_WAIT_START: begin
               if ((status & STAT_WARM) != '0) begin
                  state <= ST_BUSY;
               end else if (tmo_cnt == TMO_LIMIT) begin
                  // Abandon the job silently apart from the sticky flag
                  err_timeout <= 1'b1;
                  state       <= ST_IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            ST_BUSY: begin
               if (!ctrl_active(status)) begin
                  state    <= ST_IDLE;
                  job_done <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Zero-page offers are dropped and flagged one cycle later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         job_reject <= 1'b0;
      end else begin
         job_reject <= offer & (bus.job_pages == '0);
      end
   end

   // Page counter on printpage rising edge, regardless of FSM state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         printpage_p1 <= 1'b0;
         print_cnt    <= '0;
      end else begin
         printpage_p1 <= (status & STAT_PRINT) != '0;
         if (((status & STAT_PRINT) != '0) && !printpage_p1 && (print_cnt != '1)) begin
            print_cnt <= print_cnt + 16'd1;
         end
      end
   end

endmodule
